alu_iter: RTL

//  Pipelined-handshake successor to the single-cycle execute ALU: same 12 one-hot ops, generalised to any DATA_WIDTH.

---
 rtl/alu_iter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// Purpose: EX-stage ALU with 12 one-hot single-cycle ops and iterative unsigned mul/mulhu/divu/modu.
// Latency: single-cycle ops -> result 1 cycle after accept; iterative ops -> DATA_WIDTH+1 cycles after accept.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready low while BUSY or holding.
// Ports: clk/reset (sync, active-high), flush; in_valid/in_ready + alu_op/alu_src1/alu_src2 request;
//        out_valid/out_ready + alu_result response; busy high while an iterative op runs.
module alu_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_NUM     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_NUM-1:0]     alu_op,
  input  logic [DATA_WIDTH-1:0] alu_src1,
  input  logic [DATA_WIDTH-1:0] alu_src2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  busy
);
  localparam int SA_W  = $clog2(DATA_WIDTH);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int HW    = DATA_WIDTH / 2;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            kind;       // 0 mul, 1 mulhu, 2 divu, 3 modu
  logic [DATA_WIDTH-1:0] hi, lo;     // product {hi,lo} / remainder hi, quotient lo
  logic [DATA_WIDTH-1:0] op_b;       // multiplicand / divisor
  logic                  accept, is_multi;
  logic [1:0]            kind_sel;

  // ---------------- single-cycle datapath ----------------
  logic [SA_W-1:0]       sa;
  logic [DATA_WIDTH-1:0] sra_v, single_res;
  logic                  slt_f, sltu_f;

  assign sa     = alu_src1[SA_W-1:0];
  assign sra_v  = $unsigned($signed(alu_src2) >>> sa);
  assign slt_f  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_f = alu_src1 < alu_src2;

  always_comb begin
    single_res = '0;
    if (alu_op[0])  single_res = single_res | (alu_src1 + alu_src2);
    if (alu_op[1])  single_res = single_res | (alu_src1 - alu_src2);
    if (alu_op[2])  single_res = single_res | {{(DATA_WIDTH-1){1'b0}}, slt_f};
    if (alu_op[3])  single_res = single_res | {{(DATA_WIDTH-1){1'b0}}, sltu_f};
    if (alu_op[4])  single_res = single_res | (alu_src1 & alu_src2);
    if (alu_op[5])  single_res = single_res | ~(alu_src1 | alu_src2);
    if (alu_op[6])  single_res = single_res | (alu_src1 | alu_src2);
    if (alu_op[7])  single_res = single_res | (alu_src1 ^ alu_src2);
    if (alu_op[8])  single_res = single_res | (alu_src2 << sa);
    if (alu_op[9])  single_res = single_res | (alu_src2 >> sa);
    if (alu_op[10]) single_res = single_res | sra_v;
    if (alu_op[11]) single_res = single_res | {alu_src2[HW-1:0], {HW{1'b0}}};
  end

  // Lowest set bit among 12-15 selects the iterative op.
  assign is_multi = |alu_op[15:12];
  always_comb begin
    if (alu_op[12])      kind_sel = 2'd0;
    else if (alu_op[13]) kind_sel = 2'd1;
    else if (alu_op[14]) kind_sel = 2'd2;
    else                 kind_sel = 2'd3;
  end

  // ---------------- iterative datapath ----------------
  // Shift-add multiply: add multiplicand into hi when multiplier LSB (lo[0]) is set,
  // then shift {carry,hi,lo} right by one; lo fills with product bits from below.
  logic [DATA_WIDTH:0]   add_sum, div_shift, div_diff;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] hi_nxt, lo_nxt;

  assign add_sum   = {1'b0, hi} + {1'b0, op_b};
  // Restoring divide: bring next dividend bit (lo MSB) into the partial remainder.
  assign div_shift = {hi, lo[DATA_WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, op_b};
  assign div_ge    = div_shift >= {1'b0, op_b};

  always_comb begin
    if (kind[1]) begin
      hi_nxt = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
      lo_nxt = {lo[DATA_WIDTH-2:0], div_ge};
    end else if (lo[0]) begin
      hi_nxt = add_sum[DATA_WIDTH:1];
      lo_nxt = {add_sum[0], lo[DATA_WIDTH-1:1]};
    end else begin
      hi_nxt = {1'b0, hi[DATA_WIDTH-1:1]};
      lo_nxt = {hi[0], lo[DATA_WIDTH-1:1]};
    end
  end

  // ---------------- control ----------------
  always_comb begin
    in_ready  = !reset && !flush &&
                ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    accept    = in_valid && in_ready;
    out_valid = (state == S_DONE);
    busy      = (state == S_BUSY);
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = is_multi ? S_BUSY : S_DONE;
      S_BUSY: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE: if (out_ready) begin
        if (accept) state_nxt = is_multi ? S_BUSY : S_DONE;
        else        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      kind       <= '0;
      hi         <= '0;
      lo         <= '0;
      op_b       <= '0;
      alu_result <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        if (is_multi) begin
          cnt  <= CNT_W'(DATA_WIDTH);
          kind <= kind_sel;
          hi   <= '0;
          lo   <= alu_src1;
          op_b <= alu_src2;
        end else begin
          alu_result <= single_res;
        end
      end else if (state == S_BUSY) begin
        cnt <= cnt - CNT_W'(1);
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        // mulhu/modu take the high half, mul/divu the low half.
        if (cnt == CNT_W'(1)) alu_result <= kind[0] ? hi_nxt : lo_nxt;
      end
    end
  end
endmodule
